// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// The master side is the FSM: it takes instruction fields and datapath status,
// and drives the datapath selects and enables.
interface multicycle_ctrl_fsm_if #(
  parameter int OP_WIDTH     = 7,
  parameter int ALUCTL_WIDTH = 3
);
  // instruction fields and datapath status
  logic [OP_WIDTH-1:0]     op;
  logic [2:0]              funct3;
  logic                    funct7b5;
  logic                    Zero;
  logic                    MemReady;
  // datapath controls
  logic                    PCWrite;
  logic                    AdrSrc;
  logic                    MemRead;
  logic                    MemWrite;
  logic                    AddrType;
  logic                    IRWrite;
  logic [1:0]              ResultSrc;
  logic [1:0]              ALUSrcA;
  logic [1:0]              ALUSrcB;
  logic [ALUCTL_WIDTH-1:0] ALUControl;
  logic                    RegWrite;
  logic                    Retire;
  logic                    IllegalOp;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemRead, MemWrite, AddrType, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegWrite, Retire, IllegalOp
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemRead, MemWrite, AddrType, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegWrite, Retire, IllegalOp
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback over the shared datapath, stalling on the memory ready handshake
// and pulsing Retire / IllegalOp per instruction.
module multicycle_ctrl_fsm #(
  parameter int OP_WIDTH     = 7,
  parameter int ALUCTL_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_fsm_if.master  bus
);

  localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(7'b1100111);
  localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(7'b0110111);

  localparam logic [ALUCTL_WIDTH-1:0] ALU_ADD = ALUCTL_WIDTH'(3'b000);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_SUB = ALUCTL_WIDTH'(3'b001);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_AND = ALUCTL_WIDTH'(3'b010);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_OR  = ALUCTL_WIDTH'(3'b011);
  localparam logic [ALUCTL_WIDTH-1:0] ALU_SLT = ALUCTL_WIDTH'(3'b101);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI
  } state_t;

  state_t state, nxt;

  // funct3 -> ALU op; sub_ok separates R-type sub from I-type addi
  function automatic logic [ALUCTL_WIDTH-1:0] alu_dec(input logic [2:0] f3,
                                                       input logic sub_ok);
    case (f3)
      3'b000:  alu_dec = sub_ok ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  // state register, restarts at fetch on reset
  always_ff @(posedge clk) begin
    if (!rst) state <= S_FETCH;
    else      state <= nxt;
  end

  // next state and datapath controls; everything held low while in reset
  always_comb begin
    nxt            = state;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.AddrType   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.RegWrite   = 1'b0;
    bus.Retire     = 1'b0;
    bus.IllegalOp  = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          bus.MemRead   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          if (bus.MemReady) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            nxt         = S_DECODE;
          end
        end
        S_DECODE: begin
          // branch target precomputed into ALUOut
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
          case (bus.op)
            OP_LOAD, OP_STORE: nxt = S_MEMADR;
            OP_RTYPE:          nxt = S_EXECR;
            OP_ITYPE:          nxt = S_EXECI;
            OP_BRANCH:         nxt = S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            OP_JALR:           nxt = S_JALR;
            OP_LUI:            nxt = S_LUI;
            default: begin
              bus.IllegalOp = 1'b1;
              nxt           = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          nxt = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          bus.AdrSrc   = 1'b1;
          bus.MemRead  = 1'b1;
          bus.AddrType = (bus.funct3 == 3'b000);
          if (bus.MemReady) nxt = S_MEMWB;
        end
        S_MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
          bus.Retire    = 1'b1;
          nxt           = S_FETCH;
        end
        S_MEMWRITE: begin
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
          bus.AddrType = (bus.funct3 == 3'b000);
          if (bus.MemReady) begin
            bus.Retire = 1'b1;
            nxt        = S_FETCH;
          end
        end
        S_EXECR: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUControl = alu_dec(bus.funct3, bus.funct7b5);
          nxt            = S_ALUWB;
        end
        S_EXECI: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = alu_dec(bus.funct3, 1'b0);
          nxt            = S_ALUWB;
        end
        S_ALUWB: begin
          bus.RegWrite = 1'b1;
          bus.Retire   = 1'b1;
          nxt          = S_FETCH;
        end
        S_BRANCH: begin
          // funct3[0] distinguishes bne from beq
          bus.ALUSrcA    = 2'b10;
          bus.ALUControl = ALU_SUB;
          bus.PCWrite    = bus.Zero ^ bus.funct3[0];
          bus.Retire     = 1'b1;
          nxt            = S_FETCH;
        end
        S_JAL: begin
          // PC takes the target in ALUOut while ALU forms OldPC+4 for rd
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
          nxt         = S_ALUWB;
        end
        S_JALR: begin
          bus.ALUSrcA   = 2'b10;
          bus.ALUSrcB   = 2'b01;
          bus.ResultSrc = 2'b10;
          bus.PCWrite   = 1'b1;
          nxt           = S_ALUWB;
        end
        S_LUI: begin
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = ALU_OR;
          nxt            = S_ALUWB;
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: each instruction is run to its
// Retire/IllegalOp pulse and its per-instruction behaviour (latency, enable
// counts, ALU op, access size) is compared with a table-driven model.
module tb_multicycle_ctrl_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus ();
  multicycle_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, bus.PCWrite, bus.AdrSrc, bus.MemRead, bus.MemWrite, bus.AddrType,
            bus.IRWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
            bus.RegWrite, bus.Retire, bus.IllegalOp};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {LD, ST, RT, IT, BR, JL, JR, LU};
  endfunction

  // cycles from first FETCH cycle to the Retire / IllegalOp cycle, no stalls
  function automatic int base_lat(input logic [6:0] op);
    case (op)
      LD:                 return 5;
      ST, RT, IT, JL, JR, LU: return 4;
      BR:                 return 3;
      default:            return 2;
    endcase
  endfunction

  // ALU op in the first cycle after DECODE
  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7);
    logic [2:0] r;
    case (f3)
      3'b010: r = 3'b101;
      3'b110: r = 3'b011;
      3'b111: r = 3'b010;
      3'b000: r = (op == RT && f7) ? 3'b001 : 3'b000;
      default: r = 3'b000;
    endcase
    case (op)
      RT, IT:  return r;
      BR:      return 3'b001;
      LU:      return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // run one instruction from its first FETCH cycle; fs/ms = ready-low cycles
  // at the start of fetch and at the start of the data access
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic zero, input int fs, input int ms);
    bit mem, done;
    int msx, cyc, n_irw, irw_at, n_rw, rw_last, n_mr, n_mw, n_pcw, n_ret, n_ill, n_excl;
    logic [2:0] alu_seen;
    logic at_seen;
    mem = (op == LD || op == ST);
    msx = mem ? ms : 0;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = zero;
    {n_irw, irw_at, n_rw, rw_last, n_mr, n_mw, n_pcw, n_ret, n_ill, n_excl} = '0;
    alu_seen = '0; at_seen = 1'b0; cyc = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.MemReady = !(c < fs || (mem && c >= fs + 3 && c < fs + 3 + msx));
      @(negedge clk);
      if (c == fs + 2) alu_seen = bus.ALUControl;
      if (c == fs + 3) at_seen = bus.AddrType;
      if (bus.IRWrite) begin n_irw++; irw_at = c; end
      n_mr  += int'(bus.MemRead);
      n_mw  += int'(bus.MemWrite);
      n_pcw += int'(bus.PCWrite);
      n_ret += int'(bus.Retire);
      n_ill += int'(bus.IllegalOp);
      if (int'(bus.RegWrite) + int'(bus.MemWrite) + int'(bus.MemRead) > 1) n_excl++;
      done = bus.Retire || bus.IllegalOp;
      if (bus.RegWrite) begin n_rw++; if (done) rw_last++; end
      cyc = c + 1;
      @(posedge clk); #1;
    end
    chk("finished", 32'(done), 32'd1);
    chk("latency", cyc, base_lat(op) + fs + msx);
    chk("irwrite_cnt", n_irw, 1);
    chk("irwrite_cycle", irw_at, fs);
    chk("memread_cyc", n_mr, fs + 1 + ((op == LD) ? ms + 1 : 0));
    chk("memwrite_cyc", n_mw, (op == ST) ? ms + 1 : 0);
    chk("regwrite_cnt", n_rw, (op inside {LD, RT, IT, JL, JR, LU}) ? 1 : 0);
    chk("regwrite_last", rw_last, n_rw);
    chk("pcwrite_cnt", n_pcw, 1 + ((op == JL || op == JR) ? 1 : 0)
                               + ((op == BR && (zero ^ f3[0])) ? 1 : 0));
    chk("retire_cnt", n_ret, legal(op) ? 1 : 0);
    chk("illegal_cnt", n_ill, legal(op) ? 0 : 1);
    chk("exclusive", n_excl, 0);
    if (legal(op)) chk("aluctl", 32'(alu_seen), 32'(exp_alu(op, f3, f7)));
    if (mem) chk("addrtype", 32'(at_seen), 32'(f3 == 3'b000));
  endtask

  initial begin
    logic [6:0] optab [8];
    logic [6:0] rop;
    int k;
    optab = '{LD, ST, RT, IT, BR, JL, JR, LU};
    rst = 1'b0; bus.op = LD; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.MemReady = 1'b1;
    // reset state: all outputs low while rst is low, even with MemReady high
    repeat (2) @(posedge clk);
    @(negedge clk); chk("reset_outs", outs(), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    bus.MemReady = 1'b0;
    @(negedge clk);
    chk("post_reset_memread", 32'(bus.MemRead), 32'd1);
    chk("post_reset_fetch_sel", {bus.AdrSrc, bus.ALUSrcB, bus.IRWrite}, {1'b0, 2'b10, 1'b0});
    @(posedge clk); #1;

    // directed: add, addi, lw, sw, beq taken with MemReady high
    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(LD, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(ST, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);
    // lw with 3 stalls in fetch and memory read
    run_instr(LD, 3'b010, 1'b0, 1'b0, 3, 3);
    // bne / beq against Zero
    run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);
    // sub vs addi with instr[30] set, byte store, illegal opcode
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(ST, 3'b000, 1'b0, 1'b0, 1, 2);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);

    // reset mid-MEMREAD: lw reaches MEMREAD with memory not ready
    bus.op = LD; bus.funct3 = 3'b010; bus.MemReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.MemReady = 1'b0;
    @(negedge clk); chk("memread_pre_rst", {bus.MemRead, bus.AdrSrc}, 2'b11);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("midrst_outs", outs(), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_fetch", {bus.MemRead, bus.AdrSrc, bus.IRWrite, bus.RegWrite}, 4'b1000);
    @(posedge clk); #1;
    run_instr(LD, 3'b000, 1'b0, 1'b0, 0, 0);

    // random instruction mix with random stalls
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 8);
      if (k == 8) rop = 7'($urandom);
      else        rop = optab[k];
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
